// File: rtl/fan_speed_ctrl.sv
// -----------------------------------------------------------------------------
// fan_speed_ctrl
//
// Sits between the debounced front-panel buttons and the fan PWM generator.
// Steps the speed level OFF/LOW/MID/HIGH, soft-ramps the PWM duty toward the
// level's target one percent at a time, and runs an auto-off countdown timer.
// The motor never sees a step change in duty.
//
// Parameters:
//   RAMP_DIV    clock cycles per 1 % duty step
//   SEC_DIV     clock cycles per timer second
//   TIMER_STEP  timer base unit in seconds (5*TIMER_STEP must fit in 9 bits)
//
// Ports:
//   clk        in   system clock
//   reset_p    in   synchronous active-high reset
//   btn_speed  in   1-cycle pulse: advance speed level
//   btn_timer  in   1-cycle pulse: advance timer setting NONE/T1/T3/T5
//   btn_off    in   1-cycle pulse: force OFF and clear the timer
//   duty       out  ramped PWM duty in percent, 0..90
//   level      out  current speed level (0=OFF 1=LOW 2=MID 3=HIGH)
//   timer_sec  out  remaining auto-off seconds, 0 when not armed
//   timer_on   out  auto-off timer armed
//   ramping    out  high while duty differs from the level's target
// -----------------------------------------------------------------------------
module fan_speed_ctrl #(
    parameter int RAMP_DIV   = 1_000_000,
    parameter int SEC_DIV    = 100_000_000,
    parameter int TIMER_STEP = 60
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       btn_speed,
    input  logic       btn_timer,
    input  logic       btn_off,
    output logic [6:0] duty,
    output logic [1:0] level,
    output logic [8:0] timer_sec,
    output logic       timer_on,
    output logic       ramping
);

    localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int SEC_W  = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;

    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [RAMP_W-1:0] RAMP_ONE  = RAMP_W'(1);
    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_DIV - 1);
    localparam logic [SEC_W-1:0]  SEC_ONE   = SEC_W'(1);

    localparam logic [8:0] SEC_T1 = 9'(TIMER_STEP);
    localparam logic [8:0] SEC_T3 = 9'(3 * TIMER_STEP);
    localparam logic [8:0] SEC_T5 = 9'(5 * TIMER_STEP);

    typedef enum logic [1:0] {
        LVL_OFF  = 2'd0,
        LVL_LOW  = 2'd1,
        LVL_MID  = 2'd2,
        LVL_HIGH = 2'd3
    } level_e;

    typedef enum logic [1:0] {
        TMR_NONE = 2'd0,
        TMR_T1   = 2'd1,
        TMR_T3   = 2'd2,
        TMR_T5   = 2'd3
    } tmr_e;

    function automatic logic [6:0] target_of(input level_e l);
        logic [6:0] t;
        unique case (l)
            LVL_OFF:  t = 7'd0;
            LVL_LOW:  t = 7'd30;
            LVL_MID:  t = 7'd60;
            LVL_HIGH: t = 7'd90;
        endcase
        return t;
    endfunction

    // Registered state
    level_e            level_q;
    tmr_e              tmr_q;
    logic [RAMP_W-1:0] ramp_cnt_q;
    logic [SEC_W-1:0]  sec_cnt_q;

    // Next-state values
    level_e            level_d;
    tmr_e              tmr_d;
    logic [RAMP_W-1:0] ramp_cnt_d;
    logic [SEC_W-1:0]  sec_cnt_d;
    logic [6:0]        duty_d;
    logic [8:0]        sec_d;
    logic              on_d;
    logic              ramping_d;

    logic counting;
    logic sec_tc;
    logic expire;

    // The countdown only advances while a fan level is actually running;
    // a timer armed while OFF holds its value.
    assign counting = timer_on && (level_q != LVL_OFF);
    assign sec_tc   = counting && (sec_cnt_q == SEC_LAST);
    assign expire   = sec_tc && (timer_sec == 9'd1);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        level_d    = level_q;
        tmr_d      = tmr_q;
        sec_d      = timer_sec;
        on_d       = timer_on;
        sec_cnt_d  = sec_cnt_q;
        duty_d     = duty;
        ramp_cnt_d = ramp_cnt_q;
        ramping_d  = 1'b0;

        // Seconds prescaler and countdown
        if (counting) begin
            if (sec_tc) begin
                sec_cnt_d = '0;
                sec_d     = timer_sec - 9'd1;
            end else begin
                sec_cnt_d = sec_cnt_q + SEC_ONE;
            end
        end

        // Expiry beats btn_speed; the timer drops to NONE so that a
        // simultaneous btn_timer advances from NONE and re-arms to T1.
        if (expire) begin
            level_d = LVL_OFF;
            tmr_d   = TMR_NONE;
            on_d    = 1'b0;
        end else if (btn_speed) begin
            level_d = level_e'(level_q + 2'd1);
        end

        if (btn_timer) begin
            tmr_d     = tmr_e'(tmr_d + 2'd1);
            sec_cnt_d = '0;
            unique case (tmr_d)
                TMR_NONE: begin sec_d = 9'd0;   on_d = 1'b0; end
                TMR_T1:   begin sec_d = SEC_T1; on_d = 1'b1; end
                TMR_T3:   begin sec_d = SEC_T3; on_d = 1'b1; end
                TMR_T5:   begin sec_d = SEC_T5; on_d = 1'b1; end
            endcase
        end

        // btn_off overrides everything above
        if (btn_off) begin
            level_d   = LVL_OFF;
            tmr_d     = TMR_NONE;
            sec_d     = 9'd0;
            on_d      = 1'b0;
            sec_cnt_d = '0;
        end

        // Ramp: a target change restarts the step interval from the current
        // duty, so the first step always lands a full RAMP_DIV later.
        if (level_d != level_q) begin
            ramp_cnt_d = '0;
        end else if (ramp_cnt_q == RAMP_LAST) begin
            ramp_cnt_d = '0;
            if (duty < target_of(level_q)) begin
                duty_d = duty + 7'd1;
            end else if (duty > target_of(level_q)) begin
                duty_d = duty - 7'd1;
            end
        end else begin
            ramp_cnt_d = ramp_cnt_q + RAMP_ONE;
        end

        // Computed from next-state values so the flag tracks duty/level
        // in the same cycle they change.
        ramping_d = (duty_d != target_of(level_d));
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register update from the
        // same pre-edge values, independent of statement order.
        if (reset_p) begin
            level_q    <= LVL_OFF;
            tmr_q      <= TMR_NONE;
            ramp_cnt_q <= '0;
            sec_cnt_q  <= '0;
            duty       <= 7'd0;
            timer_sec  <= 9'd0;
            timer_on   <= 1'b0;
            ramping    <= 1'b0;
        end else begin
            level_q    <= level_d;
            tmr_q      <= tmr_d;
            ramp_cnt_q <= ramp_cnt_d;
            sec_cnt_q  <= sec_cnt_d;
            duty       <= duty_d;
            timer_sec  <= sec_d;
            timer_on   <= on_d;
            ramping    <= ramping_d;
        end
    end

    assign level = level_q;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fan_speed_ctrl
//
// Self-checking bench for fan_speed_ctrl with short dividers. Scenario tasks
// drive button pulses and compare the DUT against an integer-arithmetic model
// of the controller's rules, plus fixed values taken from the expected timing.
// -----------------------------------------------------------------------------
module tb_fan_speed_ctrl;

    localparam int RAMP_DIV   = 4;
    localparam int SEC_DIV    = 10;
    localparam int TIMER_STEP = 2;

    logic       clk;
    logic       reset_p;
    logic       btn_speed;
    logic       btn_timer;
    logic       btn_off;
    logic [6:0] duty;
    logic [1:0] level;
    logic [8:0] timer_sec;
    logic       timer_on;
    logic       ramping;

    fan_speed_ctrl #(
        .RAMP_DIV  (RAMP_DIV),
        .SEC_DIV   (SEC_DIV),
        .TIMER_STEP(TIMER_STEP)
    ) dut (
        .clk      (clk),
        .reset_p  (reset_p),
        .btn_speed(btn_speed),
        .btn_timer(btn_timer),
        .btn_off  (btn_off),
        .duty     (duty),
        .level    (level),
        .timer_sec(timer_sec),
        .timer_on (timer_on),
        .ramping  (ramping)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [19:0] dut_vec;
    assign dut_vec = {duty, level, timer_sec, timer_on, ramping};

    // ---------------- reference model ----------------
    // Level is 0..3 with target 30*level; timer setting index 0..3 maps to
    // 0,1,3,5 multiples of TIMER_STEP; phases count cycles since last clear.
    int m_level, m_idx, m_sec, m_duty, m_rph, m_sph;
    bit m_on;

    function automatic int mult(input int idx);
        return (idx == 0) ? 0 : 2 * idx - 1;
    endfunction

    function automatic void model_step(input bit s, input bit t, input bit o, input bit r);
        int lvl, idx, sec, sph, rph, n_duty;
        bit on, expired;
        if (r) begin
            m_level = 0; m_idx = 0; m_sec = 0; m_on = 0;
            m_duty = 0; m_rph = 0; m_sph = 0;
            return;
        end
        lvl = m_level; idx = m_idx; sec = m_sec; on = m_on;
        sph = m_sph; rph = m_rph; n_duty = m_duty; expired = 0;
        if (m_on && m_level != 0) begin
            if (m_sph == SEC_DIV - 1) begin
                sph = 0;
                sec = m_sec - 1;
                if (sec == 0) begin
                    expired = 1; on = 0; idx = 0; lvl = 0;
                end
            end else begin
                sph = m_sph + 1;
            end
        end
        if (s && !expired) lvl = (m_level + 1) % 4;
        if (t) begin
            idx = (idx + 1) % 4;
            sec = mult(idx) * TIMER_STEP;
            on  = (idx != 0);
            sph = 0;
        end
        if (o) begin
            lvl = 0; idx = 0; sec = 0; on = 0; sph = 0;
        end
        if (lvl != m_level) begin
            rph = 0;
        end else if (m_rph == RAMP_DIV - 1) begin
            rph = 0;
            if (m_duty < 30 * m_level) n_duty = m_duty + 1;
            else if (m_duty > 30 * m_level) n_duty = m_duty - 1;
        end else begin
            rph = m_rph + 1;
        end
        m_level = lvl; m_idx = idx; m_sec = sec; m_on = on;
        m_sph = sph; m_rph = rph; m_duty = n_duty;
    endfunction

    function automatic logic [19:0] exp_vec();
        return {7'(m_duty), 2'(m_level), 9'(m_sec), m_on, (m_duty != 30 * m_level)};
    endfunction

    function automatic string fmt(input logic [19:0] v);
        return $sformatf("duty=%0d level=%0d sec=%0d on=%0b ramping=%0b",
                         v[19:13], v[12:11], v[10:2], v[1], v[0]);
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model,
    // then release the pulses 1 time unit after the edge.
    task automatic tick(input bit s, input bit t, input bit o, input bit r);
        btn_speed = s; btn_timer = t; btn_off = o; reset_p = r;
        @(posedge clk);
        model_step(s, t, o, r);
        #1;
        btn_speed = 1'b0; btn_timer = 1'b0; btn_off = 1'b0; reset_p = 1'b0;
        cyc++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        checks++;
        if (dut_vec !== 20'd0) begin
            failures++;
            $display("FAIL reset.outputs got %s exp all zero", fmt(dut_vec));
        end
    endtask

    task automatic test_ramp_up();
        tick(1, 0, 0, 0);
        checks++;
        if (level !== 2'd1 || ramping !== 1'b1 || duty !== 7'd0) begin
            failures++;
            $display("FAIL ramp_up.press got %s exp level=1 ramping=1 duty=0", fmt(dut_vec));
        end
        for (int i = 1; i <= 120; i++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL ramp_up.model cyc=%0d got %s exp %s", cyc, fmt(dut_vec), fmt(exp_vec()));
            end
            if (i == 3 || i == 4) begin
                checks++;
                if (duty !== 7'(i / 4)) begin
                    failures++;
                    $display("FAIL ramp_up.first_step i=%0d got duty=%0d exp %0d", i, duty, i / 4);
                end
            end
        end
        checks++;
        if (duty !== 7'd30 || ramping !== 1'b0) begin
            failures++;
            $display("FAIL ramp_up.settled got %s exp duty=30 ramping=0", fmt(dut_vec));
        end
    endtask

    task automatic test_level_wrap();
        int exp_lvl[3]   = '{2, 3, 0};
        int settle[3]    = '{120, 120, 360};
        int final_duty[3] = '{60, 90, 0};
        for (int seg = 0; seg < 3; seg++) begin
            tick(1, 0, 0, 0);
            checks++;
            if (level !== 2'(exp_lvl[seg]) || ramping !== 1'b1) begin
                failures++;
                $display("FAIL level_wrap.press seg=%0d got %s exp level=%0d ramping=1",
                         seg, fmt(dut_vec), exp_lvl[seg]);
            end
            for (int i = 1; i <= settle[seg]; i++) begin
                tick(0, 0, 0, 0);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    failures++;
                    $display("FAIL level_wrap.model cyc=%0d got %s exp %s", cyc, fmt(dut_vec), fmt(exp_vec()));
                end
                if (seg == 2 && i == 359) begin
                    checks++;
                    if (duty !== 7'd1 || ramping !== 1'b1) begin
                        failures++;
                        $display("FAIL level_wrap.almost_off got %s exp duty=1 ramping=1", fmt(dut_vec));
                    end
                end
            end
            checks++;
            if (duty !== 7'(final_duty[seg]) || ramping !== 1'b0) begin
                failures++;
                $display("FAIL level_wrap.settled seg=%0d got %s exp duty=%0d ramping=0",
                         seg, fmt(dut_vec), final_duty[seg]);
            end
        end
    endtask

    task automatic test_timer_expiry();
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        repeat (240) begin
            tick(0, 0, 0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL timer_expiry.ramp cyc=%0d got %s exp %s", cyc, fmt(dut_vec), fmt(exp_vec()));
            end
        end
        tick(0, 1, 0, 0);
        checks++;
        if (timer_sec !== 9'd2 || timer_on !== 1'b1 || level !== 2'd2 || duty !== 7'd60) begin
            failures++;
            $display("FAIL timer_expiry.arm got %s exp level=2 duty=60 sec=2 on=1", fmt(dut_vec));
        end
        for (int i = 1; i <= 20; i++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL timer_expiry.model cyc=%0d got %s exp %s", cyc, fmt(dut_vec), fmt(exp_vec()));
            end
            if (i == 9 || i == 10) begin
                checks++;
                if (timer_sec !== 9'(i == 9 ? 2 : 1)) begin
                    failures++;
                    $display("FAIL timer_expiry.decrement i=%0d got sec=%0d exp %0d", i, timer_sec, i == 9 ? 2 : 1);
                end
            end
        end
        checks++;
        if (level !== 2'd0 || timer_on !== 1'b0 || timer_sec !== 9'd0 || duty !== 7'd60 || ramping !== 1'b1) begin
            failures++;
            $display("FAIL timer_expiry.expired got %s exp level=0 on=0 sec=0 duty=60 ramping=1", fmt(dut_vec));
        end
        repeat (240) begin
            tick(0, 0, 0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL timer_expiry.rampdown cyc=%0d got %s exp %s", cyc, fmt(dut_vec), fmt(exp_vec()));
            end
        end
        checks++;
        if (duty !== 7'd0 || ramping !== 1'b0) begin
            failures++;
            $display("FAIL timer_expiry.off got %s exp duty=0 ramping=0", fmt(dut_vec));
        end
    endtask

    task automatic test_timer_wrap();
        int exp_sec[4] = '{2, 6, 10, 0};
        for (int k = 0; k < 4; k++) begin
            tick(0, 1, 0, 0);
            checks++;
            if (timer_sec !== 9'(exp_sec[k]) || timer_on !== (k != 3)) begin
                failures++;
                $display("FAIL timer_wrap.setting k=%0d got sec=%0d on=%0b exp sec=%0d on=%0b",
                         k, timer_sec, timer_on, exp_sec[k], k != 3);
            end
        end
        tick(0, 1, 0, 0);
        for (int i = 0; i < 100; i++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (timer_sec !== 9'd2 || timer_on !== 1'b1 || dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL timer_wrap.hold_while_off cyc=%0d got %s exp sec=2 on=1 (%s)",
                         cyc, fmt(dut_vec), fmt(exp_vec()));
            end
        end
        tick(0, 0, 1, 0);
        checks++;
        if (timer_sec !== 9'd0 || timer_on !== 1'b0) begin
            failures++;
            $display("FAIL timer_wrap.btn_off got sec=%0d on=%0b exp sec=0 on=0", timer_sec, timer_on);
        end
    endtask

    task automatic test_simultaneous();
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        checks++;
        if (level !== 2'd3 || timer_on !== 1'b1) begin
            failures++;
            $display("FAIL simultaneous.setup got %s exp level=3 on=1", fmt(dut_vec));
        end
        tick(1, 1, 1, 0);
        checks++;
        if (level !== 2'd0 || timer_on !== 1'b0 || timer_sec !== 9'd0 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL simultaneous.off_wins got %s exp level=0 on=0 sec=0 (%s)", fmt(dut_vec), fmt(exp_vec()));
        end
        // Expiry together with btn_speed, then together with btn_timer
        for (int sc = 0; sc < 2; sc++) begin
            tick(1, 0, 0, 0);
            tick(0, 1, 0, 0);
            repeat (19) begin
                tick(0, 0, 0, 0);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    failures++;
                    $display("FAIL simultaneous.count cyc=%0d got %s exp %s", cyc, fmt(dut_vec), fmt(exp_vec()));
                end
            end
            tick(sc == 0, sc == 1, 0, 0);
            checks++;
            if (level !== 2'd0 || timer_on !== (sc == 1) || timer_sec !== 9'(sc == 1 ? 2 : 0)) begin
                failures++;
                $display("FAIL simultaneous.expiry sc=%0d got %s exp level=0 on=%0b sec=%0d",
                         sc, fmt(dut_vec), sc == 1, sc == 1 ? 2 : 0);
            end
        end
        tick(0, 0, 1, 0);
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        tick(0, 0, 0, 1);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        for (int i = 0; i < 1000 && !found; i++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL reset_mid.ramp cyc=%0d got %s exp %s", cyc, fmt(dut_vec), fmt(exp_vec()));
            end
            if (m_duty == 32) found = 1;
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL reset_mid.timeout got duty=%0d exp 32 within 1000 cycles", duty);
            return;
        end
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        repeat (50) begin
            tick(0, 0, 0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL reset_mid.model cyc=%0d got %s exp %s", cyc, fmt(dut_vec), fmt(exp_vec()));
            end
        end
        checks++;
        if (duty !== 7'd45 || timer_sec !== 9'd5 || timer_on !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid.setup got %s exp duty=45 sec=5 on=1", fmt(dut_vec));
        end
        tick(0, 0, 0, 1);
        checks++;
        if (dut_vec !== 20'd0) begin
            failures++;
            $display("FAIL reset_mid.cleared got %s exp all zero", fmt(dut_vec));
        end
        tick(1, 0, 0, 0);
        checks++;
        if (level !== 2'd1 || duty !== 7'd0) begin
            failures++;
            $display("FAIL reset_mid.press got %s exp level=1 duty=0", fmt(dut_vec));
        end
        for (int i = 1; i <= 4; i++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (duty !== 7'(i / 4)) begin
                failures++;
                $display("FAIL reset_mid.first_step i=%0d got duty=%0d exp %0d", i, duty, i / 4);
            end
        end
    endtask

    task automatic test_random();
        bit s, t, o, r;
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 29) == 0);
            t = ($urandom_range(0, 49) == 0);
            o = ($urandom_range(0, 299) == 0);
            r = ($urandom_range(0, 799) == 0);
            tick(s, t, o, r);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random.model cyc=%0d in s=%0b t=%0b o=%0b r=%0b got %s exp %s",
                         cyc, s, t, o, r, fmt(dut_vec), fmt(exp_vec()));
            end
        end
    endtask

    initial begin
        reset_p   = 1'b1;
        btn_speed = 1'b0;
        btn_timer = 1'b0;
        btn_off   = 1'b0;
        model_step(0, 0, 0, 1);
        test_reset();
        test_ramp_up();
        test_level_wrap();
        test_timer_expiry();
        test_timer_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish exp finish before 1000000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fan_speed_ctrl.md
# fan_speed_ctrl

Fan speed controller that sits between the debounced front-panel buttons and the fan PWM generator. It sequences speed levels (OFF/LOW/MID/HIGH), soft-ramps the PWM duty toward the selected level's target, and runs an auto-off countdown timer. Its `duty` output drives the PWM block directly. It replaces a direct level-to-duty lookup, so the motor never sees a step change in duty.

## Interface
- `RAMP_DIV`, default 1_000_000: clock cycles per 1-unit duty step (10 ms at 100 MHz).
- `SEC_DIV`, default 100_000_000: clock cycles per timer second.
- `TIMER_STEP`, default 60: timer base unit in seconds; must satisfy 5*TIMER_STEP ≤ 511.

Ports:
- `clk` input, 1 bit: system clock.
- `reset_p` input, 1 bit: reset, synchronous, active-high.
- `btn_speed` input, 1 bit: single-cycle pulse that advances the speed level.
- `btn_timer` input, 1 bit: single-cycle pulse that advances the timer setting.
- `btn_off` input, 1 bit: single-cycle pulse that forces OFF and clears the timer.
- `duty` output, 7 bits: ramped PWM duty in percent, range 0..90.
- `level` output, 2 bits: current speed level; 0=OFF, 1=LOW, 2=MID, 3=HIGH.
- `timer_sec` output, 9 bits: remaining auto-off seconds; 0 when the timer is not armed.
- `timer_on` output, 1 bit: auto-off timer armed.
- `ramping` output, 1 bit: high while `duty` ≠ target.

One clock domain. Reset is synchronous and active-high. All outputs are registered.

## Operation
- **Level FSM.** States are OFF→LOW→MID→HIGH→OFF, advanced by `btn_speed`.
  - Targets: OFF=0, LOW=30, MID=60, HIGH=90.
- **Timer FSM.** Settings are NONE→T1→T3→T5→NONE, advanced by `btn_timer`.
  - On entering T1/T3/T5, `timer_sec` loads TIMER_STEP, 3*TIMER_STEP or 5*TIMER_STEP respectively, and the seconds prescaler clears.
  - On entering NONE, `timer_sec`=0 and `timer_on`=0.
- **Countdown.** The seconds prescaler counts only while `timer_on`=1 and `level`≠0.
  - On each prescaler terminal count (SEC_DIV-1), `timer_sec` decrements.
  - The decrement 1→0 is expiry: `level`→0, `timer_on`→0, timer FSM→NONE, all in the same update.
  - The timer can be armed while OFF. It then holds its value until a nonzero level is selected.
- **Ramp.** The ramp prescaler counts 0..RAMP_DIV-1 continuously and clears whenever the target changes.
  - At terminal count: if `duty` < target, `duty`+1; if `duty` > target, `duty`-1; otherwise hold.
  - A target change mid-ramp redirects the ramp from the current `duty` value. There is no jump.
- **Priority within one cycle (highest first):**
  1. `btn_off`: `level`=0, timer→NONE, and `btn_speed`/`btn_timer` are ignored.
  2. Timer expiry: forces `level`=0 and ignores `btn_speed`; a simultaneous `btn_timer` re-arms to T1.
  3. `btn_speed` and `btn_timer` pulses in the same cycle both take effect.
- **Width rule.** `duty` never leaves 0..90 and never wraps. Prescaler widths are sized with $clog2 of their parameter.

## Timing
- **Reset values:** `duty`=0, `level`=0, `timer_sec`=0, `timer_on`=0, `ramping`=0. Both prescalers are 0 and both FSMs are in OFF/NONE.
- Reset asserted mid-ramp or mid-countdown returns everything to the reset values on the next edge.
- **Button response:** a pulse sampled at edge N updates `level`/`timer_on`/`timer_sec` at N+1. `ramping` also goes high at N+1 if the target now differs from `duty`.
- **First ramp step:** the first `duty` change lands RAMP_DIV cycles after the target update. A full 0→90 ramp takes 90*RAMP_DIV cycles.
- **Countdown:** the first decrement lands SEC_DIV cycles after arming, provided `level`≠0. Expiry happens at (loaded value)*SEC_DIV cycles.
- **Ramp-down:** after expiry or `btn_off`, `duty` ramps down to 0; it does not drop to 0 immediately. `ramping` deasserts on the cycle `duty` equals the target.

## Test plan
Simulation parameters: RAMP_DIV=4, SEC_DIV=10, TIMER_STEP=2.

1. **Ramp up.** Reset, then one `btn_speed` pulse → `level`=1 next cycle; `duty` steps 1,2,… every 4 cycles; `duty`=30 and `ramping`=0 after 120 cycles.
2. **Level wrap.** Three more `btn_speed` pulses, spaced so `duty` settles each time → targets 60, 90, then `level`=0 with `duty` ramping down from 90 to 0 over 360 cycles.
3. **Timer expiry.** At `level`=2, one `btn_timer` pulse → `timer_sec`=2, `timer_on`=1; `timer_sec`=1 after 10 cycles; after 20 cycles `level`=0, `timer_on`=0, and `duty` ramps from 60 to 0.
4. **Timer setting wrap.** Four `btn_timer` pulses → `timer_sec` takes 2, 6, 10, 0 and `timer_on` ends 0. While `level`=0 with T1 armed, `timer_sec` holds at 2 for 100 cycles.
5. **Simultaneous pulses.** `btn_off` together with `btn_speed` and `btn_timer` at `level`=3 → `level`=0, `timer_on`=0. Expiry together with `btn_speed` → `level`=0.
6. **Reset mid-operation.** `reset_p` asserted mid-ramp at `duty`=45 with `timer_sec`=5 → all outputs 0 on the next edge; the first ramp step after a new `btn_speed` lands exactly 4 cycles after `level` updates.
